fxp_add_arbiter: RTL and testbench
==================================

FXP_ADD_ARBITER -- requirements
Module: fxp_add_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 16, operand/result width (Qm.n total bits)
- FRAC_BITS, 8, fraction bits; passed through only, no effect on arithmetic
- NREQ, 4, number of requesters (2..8)
- MAX_OUT, 2, max in-flight operations per requester (1..4)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high (fixed)
- req_valid  in  NREQ  per-requester operation request
- req_a  in  NREQ*WIDTH  signed operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  signed operand B; same packing as req_a
- req_ready  out  NREQ  one-hot grant, combinational
- rsp_valid  out  NREQ  one-hot result strobe, one cycle, no backpressure
- rsp_sum  out  WIDTH  saturated sum, shared by all requesters
- rsp_overflow  out  1  saturation flag for rsp_sum
- ovf_clr  in  1  clears ovf_count
- ovf_count  out  16  saturating count of overflowed results
- busy  out  1  high while any operation is in flight

Function
REQ-003 The block SHALL contain one fixed_add_pipeline instance (WIDTH, FRAC_BITS passed through) with ena = any grant and rst_n = ~rst; it SHALL be the only adder.
REQ-004 Eligibility SHALL be req_valid[i] && out_cnt[i] < MAX_OUT, using registered out_cnt only; a same-cycle decrement SHALL NOT bypass into eligibility.
REQ-005 Arbitration SHALL be round-robin: search starts at rr_ptr and proceeds upward modulo NREQ; the first eligible requester is granted; at most one grant per cycle.
REQ-006 req_ready SHALL be combinational from eligibility and rr_ptr; a handshake occurs in cycle T when req_valid[i] && req_ready[i].
REQ-007 On a handshake by i, rr_ptr SHALL become (i+1) mod NREQ; with no grant it SHALL hold.
REQ-008 On a handshake, that requester's req_a/req_b slices SHALL be driven to the adder the same cycle.
REQ-009 Results SHALL appear in cycle T+4: rsp_valid[i] high for exactly one cycle; rsp_sum/rsp_overflow valid only then; results return in issue order.
REQ-010 A 4-stage {valid, id} tag shift register SHALL advance every cycle and align with adder out_valid; rsp_valid[id] = tag_valid_at_output && out_valid.
REQ-011 Saturation SHALL follow the adder: positive overflow gives 0x7FFF, negative overflow gives 0x8000, each with rsp_overflow=1; otherwise the exact sum with rsp_overflow=0.
REQ-012 out_cnt[i] SHALL increment on grant to i and decrement on rsp_valid[i]; simultaneous grant and response leaves it unchanged; it never exceeds MAX_OUT or underflows.
REQ-013 ovf_count SHALL increment on any rsp_valid with rsp_overflow=1, saturate at 0xFFFF, and clear to 0 on ovf_clr; clear wins over a simultaneous increment.
REQ-014 busy SHALL be high iff any tag stage is valid or any out_cnt is nonzero.
REQ-015 Sustained throughput SHALL be one operation per cycle whenever eligible requesters exist.

Reset
REQ-016 While rst=1 at a rising edge: rr_ptr=0, all out_cnt=0, tags invalid, ovf_count=0; in the following cycle rsp_valid=0, busy=0, and req_ready follows eligibility with rr_ptr=0.
REQ-017 Reset mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL occur for operations issued before reset.

Verification
REQ-018 Single op: req 1 issues a=0x0180, b=0x0040 at T -> rsp_valid=4'b0010 at T+4, rsp_sum=0x01C0, rsp_overflow=0.
REQ-019 Saturation: a=0x7F00, b=0x0200 -> rsp_sum=0x7FFF, ovf=1; a=0x8000, b=0xFF00 -> rsp_sum=0x8000, ovf=1; ovf_count=2.
REQ-020 Fairness: all four req_valid held high from T -> grant order 0,1,2,3,0,1,... one per cycle; each rsp_valid id matches grant order 4 cycles later.
REQ-021 Outstanding limit: only req 0 valid, MAX_OUT=2 -> grants at T, T+1; responses at T+4, T+5; next grants at T+5, T+6.
REQ-022 Reset mid-flight: three ops issued at T..T+2, rst high at T+3 -> no rsp_valid at T+4..T+6; busy=0 after reset; ovf_count=0.
REQ-023 Counter: ovf_clr asserted in the same cycle as an overflowed response -> ovf_count=0 next cycle; 65536 overflows without clear -> ovf_count holds 0xFFFF.

Source files
------------

// File: rtl/fxp_add_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one 4-stage saturating
// fixed-point adder, with per-requester outstanding limits and an overflow counter.

module fixed_add_pipeline #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic             out_valid
);
    // The binary point position does not change two's-complement addition.
    if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_frac
        $error("fixed_add_pipeline: FRAC_BITS must lie in 0..WIDTH-1");
    end

    logic             r_v1, r_v2, r_v3, r_v4;
    logic [WIDTH-1:0] r_a1, r_b1;
    logic [WIDTH:0]   r_sum2;
    logic [WIDTH-1:0] r_sum3, r_sum4;
    logic             r_ovf3, r_ovf4;

    // The pipeline advances every cycle; ena only marks which slots hold real work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_v4   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_sum2 <= '0;
            r_sum3 <= '0;
            r_sum4 <= '0;
            r_ovf3 <= 1'b0;
            r_ovf4 <= 1'b0;
        end else begin
            r_v1   <= ena;
            r_a1   <= in_a;
            r_b1   <= in_b;
            r_v2   <= r_v1;
            r_sum2 <= {r_a1[WIDTH-1], r_a1} + {r_b1[WIDTH-1], r_b1};
            r_v3   <= r_v2;
            if (r_sum2[WIDTH] != r_sum2[WIDTH-1]) begin
                r_ovf3 <= 1'b1;
                r_sum3 <= r_sum2[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                r_ovf3 <= 1'b0;
                r_sum3 <= r_sum2[WIDTH-1:0];
            end
            r_v4   <= r_v3;
            r_sum4 <= r_sum3;
            r_ovf4 <= r_ovf3;
        end
    end

    assign out_sum      = r_sum4;
    assign out_overflow = r_ovf4;
    assign out_valid    = r_v4;
endmodule

module fxp_add_arbiter #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8,
    parameter int NREQ      = 4,
    parameter int MAX_OUT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_overflow,
    input  logic                  ovf_clr,
    output logic [15:0]           ovf_count,
    output logic                  busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = 3;

    logic [IDW-1:0]    r_rr_ptr;
    logic [CW-1:0]     r_out_cnt [NREQ];
    logic [3:0]        r_tag_v;
    logic [IDW-1:0]    r_tag_id [4];
    logic [15:0]       r_ovf_count;

    logic [NREQ-1:0]   w_elig;
    logic [2*NREQ-1:0] w_dbl;
    logic [IDW-1:0]    w_off;
    logic [IDW-1:0]    w_gid;
    logic              w_found;
    logic [NREQ-1:0]   w_grant;
    logic [WIDTH-1:0]  w_a, w_b;
    logic [WIDTH-1:0]  w_sum;
    logic              w_ovf;
    logic              w_out_valid;
    logic              w_cnt_nz;
    logic              w_ovf_evt;

    // Eligibility looks only at registered counts: a response retiring this
    // cycle frees its slot from the next cycle on.
    always_comb begin
        w_cnt_nz = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i] && (r_out_cnt[i] < CW'(MAX_OUT));
            w_cnt_nz  = w_cnt_nz || (r_out_cnt[i] != '0);
        end
    end

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        int s;
        w_dbl   = {w_elig, w_elig} >> r_rr_ptr;
        w_found = |w_elig;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) w_off = IDW'(k);
        end
        s = int'(r_rr_ptr) + int'(w_off);
        if (s >= NREQ) s = s - NREQ;
        w_gid = IDW'(s);
        w_a   = '0;
        w_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_grant[i] = w_found && (w_gid == IDW'(i));
            if (w_grant[i]) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = w_grant;

    fixed_add_pipeline #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_add (
        .clk          (clk),
        .rst_n        (~rst),
        .ena          (w_found),
        .in_a         (w_a),
        .in_b         (w_b),
        .out_sum      (w_sum),
        .out_overflow (w_ovf),
        .out_valid    (w_out_valid)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_tag_v[3] && w_out_valid && (r_tag_id[3] == IDW'(i));
        end
    end

    assign rsp_sum      = w_sum;
    assign rsp_overflow = w_ovf && w_out_valid;
    assign w_ovf_evt    = (|rsp_valid) && rsp_overflow;
    assign ovf_count    = r_ovf_count;
    assign busy         = (|r_tag_v) || w_cnt_nz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_tag_v     <= '0;
            r_ovf_count <= '0;
            for (int j = 0; j < 4; j++) r_tag_id[j] <= '0;
            for (int i = 0; i < NREQ; i++) r_out_cnt[i] <= '0;
        end else begin
            if (w_found) begin
                r_rr_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
            end
            r_tag_v     <= {r_tag_v[2:0], w_found};
            r_tag_id[0] <= w_gid;
            for (int j = 1; j < 4; j++) r_tag_id[j] <= r_tag_id[j-1];
            for (int i = 0; i < NREQ; i++) begin
                case ({w_grant[i], rsp_valid[i]})
                    2'b10:   r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
                    2'b01:   r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
                    default: r_out_cnt[i] <= r_out_cnt[i];
                endcase
            end
            if (ovf_clr) begin
                r_ovf_count <= '0;
            end else if (w_ovf_evt && (r_ovf_count != 16'hFFFF)) begin
                r_ovf_count <= r_ovf_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fxp_add_arbiter.sv
// Bench for fxp_add_arbiter: a transaction-level model (queue of expected
// responses) checked every cycle, plus directed literal checks.

module tb_fxp_add_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    localparam int M = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_sum;
    logic           rsp_overflow;
    logic           ovf_clr;
    logic [15:0]    ovf_count;
    logic           busy;

    fxp_add_arbiter #(.WIDTH(W), .FRAC_BITS(8), .NREQ(N), .MAX_OUT(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_sum      (rsp_sum),
        .rsp_overflow (rsp_overflow),
        .ovf_clr      (ovf_clr),
        .ovf_count    (ovf_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          cyc = 0;
    int          exp_id_q[$];
    logic [W-1:0] exp_q[$];
    logic        exp_ovf_q[$];
    int          exp_due_q[$];
    int          m_rr = 0;
    logic [15:0] m_ovf = 16'h0;
    int          m_cnt[N];
    int          m_gid;
    int          m_s;
    logic [N-1:0] m_ready;
    logic [N-1:0] m_valid;
    logic [W-1:0] m_a, m_b, m_sum;
    logic        m_ovf_now;
    logic        m_resp_ovf;

    always @(negedge clk) begin
        if (rst) begin
            exp_id_q.delete();
            exp_q.delete();
            exp_ovf_q.delete();
            exp_due_q.delete();
            m_rr  = 0;
            m_ovf = 16'h0;
        end else begin
            chk("busy", {31'b0, busy}, {31'b0, exp_due_q.size() != 0});
            chk("ovf_count", {16'b0, ovf_count}, {16'b0, m_ovf});

            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            foreach (exp_id_q[j]) m_cnt[exp_id_q[j]]++;
            m_valid = req_valid;
            m_gid   = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (m_gid < 0 && m_valid[j] && m_cnt[j] < M) m_gid = j;
            end
            m_ready = '0;
            if (m_gid >= 0) m_ready[m_gid] = 1'b1;
            chk("req_ready", {28'b0, req_ready}, {28'b0, m_ready});

            m_resp_ovf = 1'b0;
            if (exp_due_q.size() != 0 && exp_due_q[0] == cyc) begin
                chk("rsp_valid", {28'b0, rsp_valid}, 32'(1) << exp_id_q[0]);
                chk("rsp_sum", {16'b0, rsp_sum}, {16'b0, exp_q[0]});
                chk("rsp_overflow", {31'b0, rsp_overflow}, {31'b0, exp_ovf_q[0]});
                m_resp_ovf = exp_ovf_q[0];
                void'(exp_id_q.pop_front());
                void'(exp_q.pop_front());
                void'(exp_ovf_q.pop_front());
                void'(exp_due_q.pop_front());
            end else begin
                chk("rsp_valid_idle", {28'b0, rsp_valid}, 32'h0);
            end

            if (ovf_clr) m_ovf = 16'h0;
            else if (m_resp_ovf && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;

            if (m_gid >= 0) begin
                m_a = req_a[m_gid*W +: W];
                m_b = req_b[m_gid*W +: W];
                m_s = int'($signed(m_a)) + int'($signed(m_b));
                if (m_s > 32767) begin
                    m_sum = 16'h7FFF; m_ovf_now = 1'b1;
                end else if (m_s < -32768) begin
                    m_sum = 16'h8000; m_ovf_now = 1'b1;
                end else begin
                    m_sum = 16'(m_s); m_ovf_now = 1'b0;
                end
                exp_id_q.push_back(m_gid);
                exp_q.push_back(m_sum);
                exp_ovf_q.push_back(m_ovf_now);
                exp_due_q.push_back(cyc + 4);
                m_rr = (m_gid + 1) % N;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    logic [7:0] lim_ready_pat;
    logic [7:0] lim_rsp_pat;
    logic [N-1:0] masks [8];

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
        chk("rst_ovf_count", {16'b0, ovf_count}, 32'h0);
        chk("rst_ready", {28'b0, req_ready}, 32'h0);

        // Single op from requester 1
        tick();
        set_op(1, 16'h0180, 16'h0040);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("single_ready", {28'b0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("single_rsp_valid", {28'b0, rsp_valid}, 32'h2);
        chk("single_sum", {16'b0, rsp_sum}, 32'h01C0);
        chk("single_ovf", {31'b0, rsp_overflow}, 32'h0);

        // Saturation both directions
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        set_op(0, 16'h7F00, 16'h0200);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("sat_cnt_cleared", {16'b0, ovf_count}, 32'h0);
        tick();
        set_op(0, 16'h8000, 16'hFF00);
        tick();
        req_valid = '0;
        tick(); tick();
        @(negedge clk);
        chk("sat_pos_valid", {28'b0, rsp_valid}, 32'h1);
        chk("sat_pos_sum", {16'b0, rsp_sum}, 32'h7FFF);
        chk("sat_pos_ovf", {31'b0, rsp_overflow}, 32'h1);
        tick();
        @(negedge clk);
        chk("sat_neg_sum", {16'b0, rsp_sum}, 32'h8000);
        chk("sat_neg_ovf", {31'b0, rsp_overflow}, 32'h1);
        tick();
        @(negedge clk);
        chk("sat_ovf_count", {16'b0, ovf_count}, 32'h2);

        // Fairness: all four held high after reset
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 16'(16'h0100 * (i + 1)), 16'(16'h0010 * (i + 1)));
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("fair_grant", {28'b0, req_ready}, 32'(1) << (k % 4));
            if (k >= 4) chk("fair_rsp_id", {28'b0, rsp_valid}, 32'(1) << (k % 4));
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Outstanding limit with only requester 0
        do_reset();
        lim_ready_pat = 8'b0110_0011;
        lim_rsp_pat   = 8'b0011_0000;
        set_op(0, 16'h0005, 16'h0003);
        req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("limit_ready", {31'b0, req_ready[0]}, {31'b0, lim_ready_pat[k]});
            chk("limit_rsp", {31'b0, rsp_valid[0]}, {31'b0, lim_rsp_pat[k]});
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Mixed directed vectors
        masks = '{4'b0101, 4'b1010, 4'b1100, 4'b0011, 4'b1111, 4'b0110, 4'b1001, 4'b0000};
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < N; i++) begin
                set_op(i, 16'(k * 16'h1357 + i * 16'h2468), 16'(16'hF0F0 - k * 16'h0777 + i * 16'h0101));
            end
            req_valid = masks[k % 8];
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Reset mid-flight
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 16'h7F00, 16'h0200);
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstmid_rsp_valid", {28'b0, rsp_valid}, 32'h0);
            if (k == 0) begin
                chk("rstmid_busy", {31'b0, busy}, 32'h0);
                chk("rstmid_ovf_count", {16'b0, ovf_count}, 32'h0);
            end
            tick();
        end

        // Clear wins over a simultaneous overflowed response
        set_op(0, 16'h7F00, 16'h0200);
        set_op(1, 16'h8000, 16'h8000);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (3) tick();
        ovf_clr = 1'b1;
        @(negedge clk);
        chk("clr_rsp_ovf", {31'b0, rsp_overflow}, 32'h1);
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins", {16'b0, ovf_count}, 32'h0);
        repeat (3) tick();

        // Counter saturation
        for (int i = 0; i < N; i++) set_op(i, 16'h7F00, 16'h0200);
        req_valid = 4'b1111;
        repeat (65540) tick();
        req_valid = '0;
        repeat (6) tick();
        @(negedge clk);
        chk("ovf_count_sat", {16'b0, ovf_count}, 32'hFFFF);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
